// File: rtl/axi_aw_w_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axi_aw_w_arbiter_pkg
// Local types and helpers for the AW/W arbiter: the AW output state machine
// encoding and the modulo-N index helper used by the round-robin scan.
// -----------------------------------------------------------------------------
package axi_aw_w_arbiter_pkg;

  typedef enum logic {
    AW_IDLE = 1'b0,  // m_aw_valid low
    AW_HOLD = 1'b1   // m_aw_valid high, payload frozen until m_aw_ready
  } aw_state_e;

  // (base + offset) mod n, assuming base < n and offset <= n.
  function automatic int unsigned rr_index(input int unsigned base,
                                           input int unsigned offset,
                                           input int unsigned n);
    int unsigned sum;
    sum = base + offset;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/axi_typedef_pkg.sv
// -----------------------------------------------------------------------------
// axi_typedef_pkg
// Shared AXI channel typedefs for the crossbar. Field widths are set here once
// and reused by every block that carries AW or W payloads.
//   aw_chan_t : id, addr, len, size, burst, lock, cache, prot, qos, region,
//               atop, user
//   w_chan_t  : data, strb, last, user
// -----------------------------------------------------------------------------
package axi_typedef_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned USER_W = 1;

  typedef logic [ID_W-1:0]   id_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [STRB_W-1:0] strb_t;
  typedef logic [USER_W-1:0] user_t;
  typedef logic [7:0]        len_t;
  typedef logic [2:0]        size_t;
  typedef logic [1:0]        burst_t;
  typedef logic [3:0]        cache_t;
  typedef logic [2:0]        prot_t;
  typedef logic [3:0]        qos_t;
  typedef logic [3:0]        region_t;
  typedef logic [5:0]        atop_t;

  typedef struct packed {
    id_t     id;
    addr_t   addr;
    len_t    len;
    size_t   size;
    burst_t  burst;
    logic    lock;
    cache_t  cache;
    prot_t   prot;
    qos_t    qos;
    region_t region;
    atop_t   atop;
    user_t   user;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

endpackage

// File: rtl/axi_w_route_fifo.sv
// -----------------------------------------------------------------------------
// axi_w_route_fifo
// Small FIFO of requester indices recording AW grant order so W bursts can be
// steered to the shared port in the same order.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   push, push_data  enqueue a grant index (ignored when full)
//   pop           dequeue the head (ignored when empty)
//   head          index at the head of the FIFO
//   full, empty   status, both derived from the registered count
// -----------------------------------------------------------------------------
module axi_w_route_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only read
  // once the count says they were written, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/axi_aw_w_arbiter.sv
// -----------------------------------------------------------------------------
// axi_aw_w_arbiter
// Shares one downstream AXI write path (AW + W) between NUM_REQ requesters.
// AW is arbitrated round-robin into a registered, AXI-stable output; each
// grant index is pushed into a route FIFO whose head steers W beats to the
// shared port, so W bursts follow AW grant order and never precede their AW.
// Optional feature macro: AXI_ARB_QOS_EN -- when defined, only requesters
// carrying the highest valid qos compete, round-robin among themselves.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   s_aw_valid/ready/chan [NUM_REQ]   upstream AW channels
//   s_w_valid/ready/chan  [NUM_REQ]   upstream W channels
//   m_aw_valid/ready/chan             downstream AW (valid/payload registered)
//   m_w_valid/ready/chan              downstream W (combinational from head)
// -----------------------------------------------------------------------------
module axi_aw_w_arbiter
  import axi_typedef_pkg::*;
  import axi_aw_w_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ROUTE_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic     [NUM_REQ-1:0]   s_aw_valid,
  output logic     [NUM_REQ-1:0]   s_aw_ready,
  input  aw_chan_t [NUM_REQ-1:0]   s_aw_chan,
  input  logic     [NUM_REQ-1:0]   s_w_valid,
  output logic     [NUM_REQ-1:0]   s_w_ready,
  input  w_chan_t  [NUM_REQ-1:0]   s_w_chan,
  output logic                     m_aw_valid,
  input  logic                     m_aw_ready,
  output aw_chan_t                 m_aw_chan,
  output logic                     m_w_valid,
  input  logic                     m_w_ready,
  output w_chan_t                  m_w_chan
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  aw_state_e          state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  aw_chan_t           m_aw_chan_q, m_aw_chan_d;

  logic [NUM_REQ-1:0] cand;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               aw_grant;

  logic               route_push, route_pop;
  logic [IDX_W-1:0]   route_head;
  logic               route_full, route_empty;

  // ---------------------------------------------------------------------------
  // Winner selection: first candidate at or after rr_ptr, wrapping.
  // ---------------------------------------------------------------------------
`ifdef AXI_ARB_QOS_EN
  qos_t max_qos;
`endif

  always_comb begin
    cand      = s_aw_valid;
    win_found = 1'b0;
    win_idx   = '0;
`ifdef AXI_ARB_QOS_EN
    max_qos = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (s_aw_valid[i] && (s_aw_chan[i].qos > max_qos)) max_qos = s_aw_chan[i].qos;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (s_aw_chan[i].qos != max_qos) cand[i] = 1'b0;
    end
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = rr_index(int'(rr_ptr_q), k, NUM_REQ);
      if (!win_found && cand[idx[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[IDX_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // AW state machine. A grant may only happen while the output register is
  // free (IDLE) or being emptied this cycle (HOLD with m_aw_ready), and only
  // while the route FIFO has room by its registered count.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    m_aw_chan_d = m_aw_chan_q;
    s_aw_ready  = '0;
    route_push  = 1'b0;
    aw_grant    = win_found && ((state_q == AW_IDLE) || m_aw_ready) && !route_full;

    if (aw_grant) begin
      s_aw_ready[win_idx] = 1'b1;
      m_aw_chan_d         = s_aw_chan[win_idx];
      route_push          = 1'b1;
      rr_ptr_d            = IDX_W'(rr_index(int'(win_idx), 1, NUM_REQ));
      state_d             = AW_HOLD;
    end else if ((state_q == AW_HOLD) && m_aw_ready) begin
      state_d = AW_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= AW_IDLE;
      rr_ptr_q    <= '0;
      m_aw_chan_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      m_aw_chan_q <= m_aw_chan_d;
    end
  end

  assign m_aw_valid = (state_q == AW_HOLD);
  assign m_aw_chan  = m_aw_chan_q;

  // ---------------------------------------------------------------------------
  // Route FIFO and W steering. Only the head requester sees m_w_ready.
  // ---------------------------------------------------------------------------
  axi_w_route_fifo #(
    .DEPTH (ROUTE_DEPTH),
    .WIDTH (IDX_W)
  ) u_route_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (route_push),
    .push_data (win_idx),
    .pop       (route_pop),
    .head      (route_head),
    .full      (route_full),
    .empty     (route_empty)
  );

  always_comb begin
    s_w_ready = '0;
    m_w_valid = 1'b0;
    m_w_chan  = '0;
    if (!route_empty) begin
      m_w_valid             = s_w_valid[route_head];
      m_w_chan              = s_w_chan[route_head];
      s_w_ready[route_head] = m_w_ready;
    end
  end

  assign route_pop = m_w_valid & m_w_ready & m_w_chan.last;

endmodule

// File: tb/tb_axi_aw_w_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_aw_w_arbiter
// Directed bench for axi_aw_w_arbiter. A queue-based model of the arbiter
// (grant queue, held AW payload, rotating pointer) predicts the outputs every
// cycle; literal expectations pin grant order, beat counts and latencies.
// Inputs change 1 ns after posedge; outputs are compared on negedge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_aw_w_arbiter;
  import axi_typedef_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int ROUTE_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic     [NUM_REQ-1:0] s_aw_valid, s_aw_ready, s_w_valid, s_w_ready;
  aw_chan_t [NUM_REQ-1:0] s_aw_chan;
  w_chan_t  [NUM_REQ-1:0] s_w_chan;
  logic     m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
  aw_chan_t m_aw_chan;
  w_chan_t  m_w_chan;

  always #5 clk = ~clk;

  axi_aw_w_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ROUTE_DEPTH (ROUTE_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_aw_valid (s_aw_valid),
    .s_aw_ready (s_aw_ready),
    .s_aw_chan  (s_aw_chan),
    .s_w_valid  (s_w_valid),
    .s_w_ready  (s_w_ready),
    .s_w_chan   (s_w_chan),
    .m_aw_valid (m_aw_valid),
    .m_aw_ready (m_aw_ready),
    .m_aw_chan  (m_aw_chan),
    .m_w_valid  (m_w_valid),
    .m_w_ready  (m_w_ready),
    .m_w_chan   (m_w_chan)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Upstream sources: per-requester AW request queue and W burst queue.
  // ---------------------------------------------------------------------------
  aw_chan_t aw_src_q [NUM_REQ][$];
  int       w_src_q  [NUM_REQ][$];  // remaining beats of each pending burst
  int       w_beat_no  [NUM_REQ];
  int       w_burst_no [NUM_REQ];
  logic [NUM_REQ-1:0] w_en;
  logic [NUM_REQ-1:0] aw_hs, w_hs;

  task automatic drive_sources();
    for (int r = 0; r < NUM_REQ; r++) begin
      s_aw_valid[r] = (aw_src_q[r].size() > 0);
      s_aw_chan[r]  = (aw_src_q[r].size() > 0) ? aw_src_q[r][0] : '0;
      s_w_valid[r]  = w_en[r] && (w_src_q[r].size() > 0);
      s_w_chan[r]      = '0;
      s_w_chan[r].data = {8'(r), 8'(w_burst_no[r]), 16'(w_beat_no[r])};
      s_w_chan[r].strb = '1;
      s_w_chan[r].last = (w_src_q[r].size() > 0) && (w_src_q[r][0] == 1);
    end
  endtask

  task automatic clear_sources();
    for (int r = 0; r < NUM_REQ; r++) begin
      aw_src_q[r].delete();
      w_src_q[r].delete();
      w_beat_no[r]  = 0;
      w_burst_no[r] = 0;
    end
  endtask

  task automatic push_aw(input int r, input logic [31:0] addr, input int len, input int qos);
    aw_chan_t c;
    c       = '0;
    c.id    = ID_W'(r);
    c.addr  = addr;
    c.len   = 8'(len);
    c.size  = 3'd2;
    c.burst = 2'd1;
    c.qos   = 4'(qos);
    aw_src_q[r].push_back(c);
    w_src_q[r].push_back(len + 1);
  endtask

  // One clock: wait for the edge, retire the handshakes seen at the previous
  // negedge (unless reset was active at that edge), then drive new values.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (aw_hs[r] && aw_src_q[r].size() > 0) void'(aw_src_q[r].pop_front());
        if (w_hs[r] && w_src_q[r].size() > 0) begin
          if (w_src_q[r][0] == 1) begin
            void'(w_src_q[r].pop_front());
            w_beat_no[r] = 0;
            w_burst_no[r]++;
          end else begin
            w_src_q[r][0] = w_src_q[r][0] - 1;
            w_beat_no[r]++;
          end
        end
      end
    end
    drive_sources();
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: list of outstanding grants plus the held AW beat.
  // ---------------------------------------------------------------------------
  bit       mdl_live = 0;
  bit       mdl_hold;
  aw_chan_t mdl_aw;
  int       mdl_rr;
  int       mdl_routes[$];

  function automatic int mdl_winner();
    int best;
    best = -1;
    if (mdl_hold && !m_aw_ready) return -1;
    if (mdl_routes.size() >= ROUTE_DEPTH) return -1;
    for (int r = 0; r < NUM_REQ; r++) begin
`ifdef AXI_ARB_QOS_EN
      if (s_aw_valid[r] && int'(s_aw_chan[r].qos) > best) best = int'(s_aw_chan[r].qos);
`else
      if (s_aw_valid[r]) best = 0;
`endif
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      int r;
      r = (mdl_rr + k) % NUM_REQ;
`ifdef AXI_ARB_QOS_EN
      if (s_aw_valid[r] && int'(s_aw_chan[r].qos) == best) return r;
`else
      if (s_aw_valid[r]) return r;
`endif
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model_update
    int g;
    int h;
    if (!rst_n) begin
      mdl_live = 1;
      mdl_hold = 0;
      mdl_aw   = '0;
      mdl_rr   = 0;
      mdl_routes.delete();
    end else if (mdl_live) begin
      g = mdl_winner();
      if (mdl_routes.size() > 0) begin
        h = mdl_routes[0];
        if (s_w_valid[h] && m_w_ready && s_w_chan[h].last) void'(mdl_routes.pop_front());
      end
      if (g >= 0) begin
        mdl_routes.push_back(g);
        mdl_aw   = s_aw_chan[g];
        mdl_rr   = (g + 1) % NUM_REQ;
        mdl_hold = 1;
      end else if (m_aw_ready) begin
        mdl_hold = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Negedge: record handshakes, log observed events, compare against model.
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int grant_log[$], grant_cyc[$];
  int wlast_log[$], wlast_cyc[$];
  int aw_rise_cyc[$];
  int beats_from[NUM_REQ];
  logic prev_aw_valid = 1'b0;

  task automatic clear_logs();
    grant_log.delete(); grant_cyc.delete();
    wlast_log.delete(); wlast_cyc.delete();
    aw_rise_cyc.delete();
    for (int r = 0; r < NUM_REQ; r++) beats_from[r] = 0;
  endtask

  always @(negedge clk) begin : compare
    int g;
    int h;
    logic [NUM_REQ-1:0] exp_aw_ready, exp_w_ready;
    logic exp_w_valid;
    cyc++;
    aw_hs = s_aw_valid & s_aw_ready;
    w_hs  = s_w_valid & s_w_ready;
    if (rst_n) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (aw_hs[r]) begin grant_log.push_back(r); grant_cyc.push_back(cyc); end
      end
      if (m_w_valid && m_w_ready) begin
        beats_from[int'(m_w_chan.data[31:24]) % NUM_REQ]++;
        if (m_w_chan.last) begin
          wlast_log.push_back(int'(m_w_chan.data[31:24]));
          wlast_cyc.push_back(cyc);
        end
      end
      if (m_aw_valid && !prev_aw_valid) aw_rise_cyc.push_back(cyc);
    end
    prev_aw_valid = m_aw_valid;

    if (mdl_live) begin
      g = mdl_winner();
      exp_aw_ready = '0;
      if (g >= 0) exp_aw_ready[g] = 1'b1;
      exp_w_valid = 1'b0;
      exp_w_ready = '0;
      h = -1;
      if (mdl_routes.size() > 0) begin
        h = mdl_routes[0];
        exp_w_valid    = s_w_valid[h];
        exp_w_ready[h] = m_w_ready;
      end
      check("m_aw_valid", 128'(m_aw_valid), 128'(mdl_hold));
      if (mdl_hold) check("m_aw_chan", 128'(m_aw_chan), 128'(mdl_aw));
      check("s_aw_ready", 128'(s_aw_ready), 128'(exp_aw_ready));
      check("m_w_valid", 128'(m_w_valid), 128'(exp_w_valid));
      check("s_w_ready", 128'(s_w_ready), 128'(exp_w_ready));
      if (exp_w_valid) check("m_w_chan", 128'(m_w_chan), 128'(s_w_chan[h]));
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    clear_sources();
    drive_sources();
    step();
    step();
    rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin : main
    int n;
    rst_n      = 1'b0;
    m_aw_ready = 1'b0;
    m_w_ready  = 1'b0;
    w_en       = '0;
    aw_hs      = '0;
    w_hs       = '0;
    clear_sources();
    clear_logs();
    drive_sources();
    step();
    step();
    // Reset state
    check("rst m_aw_valid", 128'(m_aw_valid), 128'(0));
    check("rst m_aw_chan",  128'(m_aw_chan),  128'(0));
    check("rst s_aw_ready", 128'(s_aw_ready), 128'(0));
    check("rst m_w_valid",  128'(m_w_valid),  128'(0));
    check("rst s_w_ready",  128'(s_w_ready),  128'(0));
    rst_n = 1'b1;
    clear_logs();

    // 1. Single requester 2, len 3
    m_aw_ready = 1'b1;
    m_w_ready  = 1'b1;
    w_en       = '1;
    push_aw(2, 32'h0000_2000, 3, 0);
    drive_sources();
    repeat (8) step();
    check("t1 grant count", 128'(grant_log.size()), 128'(1));
    if (grant_log.size() > 0) check("t1 grant idx", 128'(grant_log[0]), 128'(2));
    if (grant_log.size() > 0 && aw_rise_cyc.size() > 0)
      check("t1 aw latency", 128'(aw_rise_cyc[0] - grant_cyc[0]), 128'(1));
    else check("t1 aw rise seen", 128'(aw_rise_cyc.size()), 128'(1));
    check("t1 beats r2", 128'(beats_from[2]), 128'(4));
    check("t1 bursts", 128'(wlast_log.size()), 128'(1));
    check("t1 w idle", 128'(m_w_valid), 128'(0));

    // 2. All four valid, grant order 0,1,2,3,0 on consecutive cycles
    do_reset();
    m_aw_ready = 1'b1;
    m_w_ready  = 1'b1;
    w_en       = '1;
    push_aw(0, 32'h0000_0100, 1, 0);
    push_aw(1, 32'h0000_1100, 1, 0);
    push_aw(2, 32'h0000_2100, 1, 0);
    push_aw(3, 32'h0000_3100, 1, 0);
    push_aw(0, 32'h0000_0200, 1, 0);
    drive_sources();
    repeat (20) step();
    check("t2 grant count", 128'(grant_log.size()), 128'(5));
    check("t2 burst count", 128'(wlast_log.size()), 128'(5));
    n = (grant_log.size() < 5) ? grant_log.size() : 5;
    for (int i = 0; i < n; i++) begin
      check("t2 grant order", 128'(grant_log[i]), 128'(i % 4));
      check("t2 grant cycle", 128'(grant_cyc[i] - grant_cyc[0]), 128'(i));
    end
    n = (wlast_log.size() < 5) ? wlast_log.size() : 5;
    for (int i = 0; i < n; i++) check("t2 w order", 128'(wlast_log[i]), 128'(i % 4));

    // 3. HOLD with m_aw_ready low for 5 cycles; W completes meanwhile
    clear_logs();
    m_aw_ready = 1'b0;
    push_aw(1, 32'h0000_1234, 2, 0);
    push_aw(2, 32'h0000_2234, 0, 0);
    drive_sources();
    repeat (6) step();
    check("t3 single grant", 128'(grant_log.size()), 128'(1));
    if (grant_log.size() > 0) check("t3 grant idx", 128'(grant_log[0]), 128'(1));
    check("t3 held valid", 128'(m_aw_valid), 128'(1));
    check("t3 held addr", 128'(m_aw_chan.addr), 128'(32'h0000_1234));
    check("t3 w during hold", 128'(beats_from[1]), 128'(3));
    m_aw_ready = 1'b1;
    drive_sources();
    repeat (6) step();
    check("t3 grants after", 128'(grant_log.size()), 128'(2));
    if (grant_log.size() > 1) check("t3 second idx", 128'(grant_log[1]), 128'(2));

    // 4. Route FIFO full blocks grants; one pop frees a slot a cycle later
    do_reset();
    m_aw_ready = 1'b1;
    m_w_ready  = 1'b1;
    w_en       = '0;
    push_aw(0, 32'h0000_0400, 0, 0);
    push_aw(0, 32'h0000_0500, 0, 0);
    push_aw(1, 32'h0000_1400, 0, 0);
    push_aw(2, 32'h0000_2400, 0, 0);
    push_aw(3, 32'h0000_3400, 0, 0);
    push_aw(1, 32'h0000_1500, 0, 0);
    drive_sources();
    repeat (8) step();
    check("t4 grants at full", 128'(grant_log.size()), 128'(4));
    check("t4 blocked ready", 128'(s_aw_ready), 128'(0));
    w_en[0] = 1'b1;
    drive_sources();
    repeat (6) step();
    check("t4 grants after pop", 128'(grant_log.size()), 128'(5));
    check("t4 one burst", 128'(wlast_log.size()), 128'(1));
    if (grant_log.size() > 4 && wlast_cyc.size() > 0) begin
      check("t4 fifth idx", 128'(grant_log[4]), 128'(0));
      check("t4 grant after pop", 128'(grant_cyc[4] - wlast_cyc[0]), 128'(1));
    end
    check("t4 head blocked", 128'(m_w_valid), 128'(0));

    // 5. Reset mid-burst (after beat 2 of 4)
    do_reset();
    m_aw_ready = 1'b1;
    m_w_ready  = 1'b1;
    w_en       = '1;
    push_aw(2, 32'h0000_2800, 3, 0);
    drive_sources();
    n = 0;
    while (beats_from[2] < 2 && n < 20) begin step(); n++; end
    check("t5 reached beat 2", 128'(beats_from[2]), 128'(2));
    rst_n = 1'b0;
    step();
    check("t5 m_aw_valid", 128'(m_aw_valid), 128'(0));
    check("t5 src w still valid", 128'(s_w_valid[2]), 128'(1));
    check("t5 m_w_valid", 128'(m_w_valid), 128'(0));
    check("t5 s_w_ready", 128'(s_w_ready), 128'(0));
    clear_sources();
    drive_sources();
    step();
    rst_n = 1'b1;
    clear_logs();
    push_aw(3, 32'h0000_3900, 0, 0);
    push_aw(1, 32'h0000_1900, 0, 0);
    drive_sources();
    repeat (6) step();
    check("t5 grants", 128'(grant_log.size()), 128'(2));
    if (grant_log.size() > 1) begin
      check("t5 rr restart first", 128'(grant_log[0]), 128'(1));
      check("t5 rr restart second", 128'(grant_log[1]), 128'(3));
    end

    // 6. qos: requester 0 (qos 1) vs 3 (qos 7), then equal qos
    do_reset();
    m_aw_ready = 1'b1;
    m_w_ready  = 1'b1;
    w_en       = '1;
    push_aw(0, 32'h0000_0a00, 0, 1);
    push_aw(3, 32'h0000_3a00, 0, 7);
    drive_sources();
    repeat (6) step();
    check("t6 grants", 128'(grant_log.size()), 128'(2));
    if (grant_log.size() > 1) begin
`ifdef AXI_ARB_QOS_EN
      check("t6 qos first", 128'(grant_log[0]), 128'(3));
      check("t6 qos second", 128'(grant_log[1]), 128'(0));
`else
      check("t6 rr first", 128'(grant_log[0]), 128'(0));
      check("t6 rr second", 128'(grant_log[1]), 128'(3));
`endif
    end
    clear_logs();
    push_aw(0, 32'h0000_0b00, 0, 5);
    push_aw(2, 32'h0000_2b00, 0, 5);
    drive_sources();
    repeat (6) step();
    check("t6 eq grants", 128'(grant_log.size()), 128'(2));
    if (grant_log.size() > 1) begin
`ifdef AXI_ARB_QOS_EN
      check("t6 eq first", 128'(grant_log[0]), 128'(2));
      check("t6 eq second", 128'(grant_log[1]), 128'(0));
`else
      check("t6 eq first", 128'(grant_log[0]), 128'(0));
      check("t6 eq second", 128'(grant_log[1]), 128'(2));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_aw_w_arbiter.md
# axi_aw_w_arbiter

- Shares one downstream AXI write path between NUM_REQ upstream requesters.
- AW: round-robin arbitration with a registered, AXI-stable output.
- W: each granted requester's beats are steered to the shared port in AW grant order, using a small route FIFO of grant indices.
- Sits in the crossbar in front of each slave-side port; B/AR/R handling is out of scope (separate blocks).

## Interface
Parameters:
- NUM_REQ, 4, number of upstream requesters (≥2).
- ROUTE_DEPTH, 4, route FIFO entries = max AW grants outstanding without completed W burst (≥1).

Ports (clock and reset: one clock; reset is synchronous and active-low):
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- s_aw_valid  in  NUM_REQ  per-requester AW valid.
- s_aw_ready  out  NUM_REQ  per-requester AW ready; one-hot or zero.
- s_aw_chan  in  NUM_REQ × aw_chan_t  per-requester AW payload: id, addr, len, size, burst, lock, cache, prot, qos, region, atop, user.
- s_w_valid  in  NUM_REQ  per-requester W valid.
- s_w_ready  out  NUM_REQ  per-requester W ready; one-hot or zero.
- s_w_chan  in  NUM_REQ × w_chan_t  per-requester W payload: data, strb, last, user.
- m_aw_valid  out  1  downstream AW valid (registered).
- m_aw_ready  in  1  downstream AW ready.
- m_aw_chan  out  aw_chan_t  downstream AW payload (registered).
- m_w_valid  out  1  downstream W valid (combinational from route head).
- m_w_ready  in  1  downstream W ready.
- m_w_chan  out  w_chan_t  downstream W payload (combinational mux).

## Operation
AW state machine, two states:
- IDLE: m_aw_valid=0.
- HOLD: m_aw_valid=1; m_aw_chan held constant.

Grant condition:
- Evaluated in IDLE, or in HOLD in the same cycle m_aw_ready=1.
- Requires at least one s_aw_valid and route count < ROUTE_DEPTH.
- Winner g is the first asserted s_aw_valid scanning from rr_ptr upward, modulo NUM_REQ.

On a grant in the cycle:
- s_aw_ready[g]=1.
- m_aw_chan ← s_aw_chan[g].
- Push g into the route FIFO.
- rr_ptr ← (g+1) mod NUM_REQ.
- State → HOLD.

HOLD transitions:
- m_aw_ready=1 and no grant → IDLE.
- m_aw_ready=1 with grant → stay HOLD with the new payload (back-to-back, 1 AW per cycle).
- m_aw_ready=0 → hold; no grant taken.

W steering:
- Route FIFO non-empty, head h: m_w_valid=s_w_valid[h], m_w_chan=s_w_chan[h], s_w_ready[h]=m_w_ready; all other s_w_ready=0.
- Route FIFO empty: m_w_valid=0 and all s_w_ready=0. W never passes ahead of its AW grant.
- Pop the head on m_w_valid & m_w_ready & m_w_chan.last.

## Timing
- Reset values: m_aw_valid=0, m_aw_chan='0, state IDLE, rr_ptr=0, route FIFO empty (count 0, pointers 0), s_aw_ready='0. With the FIFO empty, m_w_valid=0 and s_w_ready='0.
- Reset asserted mid-operation discards the in-flight AW and all routes; outputs reach reset values after that edge.
- AW latency: upstream handshake in cycle N → m_aw_valid=1 in cycle N+1.
- W latency: zero (combinational path), starting from the cycle after the grant's push.
- Full check uses the registered count. A pop in the same cycle does not free a slot for a grant; full at ROUTE_DEPTH blocks grants until the next cycle.
- Push and pop in the same cycle are allowed when not full; count is unchanged.
- Count width is clog2(ROUTE_DEPTH+1); pointers wrap modulo ROUTE_DEPTH.
- A W burst whose AW has been granted may complete while its AW is still held in HOLD.

## Configuration
- AXI_ARB_QOS_EN defined:
  - The candidate set is restricted to asserted requesters with the maximum s_aw_chan.qos.
  - Round-robin from rr_ptr applies within that set.
- AXI_ARB_QOS_EN undefined: pure round-robin; qos is passed through only.

## Structure
- aw_chan_t, w_chan_t and the field types (len_t, size_t, burst_t, cache_t, prot_t, qos_t, region_t, atop_t) live in axi_typedef_pkg, parameterised widths shared with the crossbar.
- Sub-module axi_w_route_fifo: a ROUTE_DEPTH × clog2(NUM_REQ) FIFO with push, pop, head, full and empty.

## Test plan
- Single requester: s_aw_valid[2]=1, len=3 → m_aw_valid in the next cycle, m_aw_chan matching requester 2; exactly 4 beats forwarded from requester 2; FIFO empty after the last beat.
- All four s_aw_valid held high, m_aw_ready=1 → grant order 0,1,2,3,0 on consecutive cycles; W bursts emerge in the same order.
- m_aw_ready=0 for 5 cycles with HOLD active → m_aw_chan stable, no s_aw_ready asserted, no FIFO push.
- ROUTE_DEPTH=4, no W traffic → exactly 4 grants, then s_aw_ready=0. One completed W burst pops the FIFO; the next grant happens one cycle later.
- rst_n=0 mid-burst (beat 2 of 4) → next cycle m_aw_valid=0, m_w_valid=0, rr_ptr=0, FIFO empty.
- AXI_ARB_QOS_EN: requesters 0 (qos 1) and 3 (qos 7) valid → 3 granted first; with equal qos, order follows rr_ptr.
